fifo_flagged: RTL and testbench
===============================

Name: fifo_flagged

Overview:
- Parametrised synchronous FIFO for the cache subsystem, used for miss-request, writeback and snoop queues between cache controller and bus interface.
- Generalises the plain push/pop FIFO with:
  - an occupancy counter wide enough to hold DEPTH,
  - full/empty and programmable almost-full/almost-empty flags,
  - overflow/underflow protection with sticky error flags,
  - a synchronous flush.
- Reads are first-word fall-through: the head entry is visible on data_out whenever the FIFO is non-empty.

Parameters:
- FIFO_WIDTH, 32, data word width in bits (≥1).
- FIFO_DEPTH, 8, number of entries; power of two, ≥2.
- FIFO_PNTR_W, 3, pointer width; must equal log2(FIFO_DEPTH).
- FIFO_CNTR_W, 4, occupancy counter width; must equal FIFO_PNTR_W+1.
- AF_THRESH, 6, almost_full asserts when cnt ≥ AF_THRESH (1..FIFO_DEPTH).
- AE_THRESH, 2, almost_empty asserts when cnt ≤ AE_THRESH (0..FIFO_DEPTH-1).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- FIFO_clr_n  input  1  asynchronous active-low reset.
- FIFO_reset_n  input  1  synchronous active-low flush.
- push  input  1  write request.
- pop  input  1  read/advance request.
- data_in  input  FIFO_WIDTH  write data.
- err_clr  input  1  synchronous clear of the sticky error flags.
- data_out  output  FIFO_WIDTH  head entry; 0 when empty.
- cnt  output  FIFO_CNTR_W  current occupancy, 0..FIFO_DEPTH.
- full  output  1  cnt == FIFO_DEPTH.
- empty  output  1  cnt == 0.
- almost_full  output  1  cnt ≥ AF_THRESH.
- almost_empty  output  1  cnt ≤ AE_THRESH.
- overflow  output  1  sticky: a push was dropped.
- underflow  output  1  sticky: a pop was ignored.

Behaviour:
- Reset (FIFO_clr_n low): asynchronous.
  - Write pointer, read pointer and cnt clear to 0; overflow and underflow clear to 0.
  - Outputs settle to: empty=1, full=0, almost_empty=1, almost_full=0 (AF_THRESH≥1), data_out=0.
  - Memory contents are not cleared. data_out is masked to 0 while empty, so stale data is never observable.
- Flush (FIFO_reset_n low at a clock edge): same state effect as reset, applied synchronously. Takes priority over push, pop and err_clr in that cycle.
- Storage: FIFO_DEPTH×FIFO_WIDTH array.
  - Pointers are FIFO_PNTR_W bits and wrap naturally from DEPTH-1 to 0.
  - cnt is a separate FIFO_CNTR_W-bit register, so full and empty are unambiguous.
- Flags: all derived combinationally from registered cnt; no combinational path from push or pop to any output.
- Accepted push (push=1 and not full, or push=1 with an accepted pop in the same cycle):
  - mem[wptr] ← data_in; wptr+1.
- Accepted pop (pop=1 and not empty):
  - rptr+1.
  - data_out shows the new head on the following cycle.
- Per-cycle action table (when not flushing):
  - 10, not full: write; cnt+1.
  - 10, full: write dropped; state unchanged; overflow←1.
  - 01, not empty: read; cnt-1.
  - 01, empty: ignored; underflow←1.
  - 11, not empty and not full: write and read; cnt unchanged.
  - 11, full: write and read both accepted; the write goes to the slot being vacated; cnt stays DEPTH; no overflow.
  - 11, empty: push accepted, pop ignored; cnt←1; underflow←1. No fall-through bypass of data_in to data_out in the same cycle.
  - 00: hold.
- Write latency: a word pushed at edge N is visible on data_out after edge N if the FIFO was empty.
- Order: strictly first-in first-out across pointer wrap-around.
- Sticky errors:
  - overflow and underflow stay set until err_clr=1 at an edge, or until flush/reset.
  - If err_clr and a new error event occur in the same cycle, the flag remains set (set wins).
- Reset asserted mid-operation: immediate return to the empty state; the partial cycle has no effect.

Test Plan:
- Reset, then idle -> cnt=0, empty=1, almost_empty=1, full=0, data_out=0, overflow=underflow=0.
- Push 0xA0..0xA7 on 8 consecutive cycles (DEPTH=8) -> full=1, cnt=8; almost_full asserts at cnt=6.
  - Pop 8 times -> data_out sequence 0xA0..0xA7, ending with empty=1.
- Fill to 8, push 0xFF -> cnt stays 8, overflow=1, and the 0xFF word never appears on data_out.
  - err_clr for 1 cycle -> overflow=0.
- Push and pop together for 20 cycles starting at cnt=3 (pointer wrap) -> cnt stays 3, FIFO order preserved across the wrap.
  - Push and pop together while full -> cnt=8, no overflow.
- Push and pop together while empty, push data 0x5 -> cnt=1, underflow=1, data_out=0x5 on the next cycle.
- Fill to 5, pulse FIFO_reset_n low for 1 cycle with push=1 -> cnt=0, empty=1, data_out=0.
  - Separately, assert FIFO_clr_n low between edges -> outputs clear without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_flagged.sv
// Synchronous first-word fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, sticky overflow/underflow and a synchronous flush.
module fifo_flagged #(
    parameter int FIFO_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_PNTR_W = 3,
    parameter int FIFO_CNTR_W = 4,
    parameter int AF_THRESH   = 6,
    parameter int AE_THRESH   = 2
) (
    input  logic                   clk,
    input  logic                   FIFO_clr_n,
    input  logic                   FIFO_reset_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [FIFO_WIDTH-1:0]  data_in,
    input  logic                   err_clr,
    output logic [FIFO_WIDTH-1:0]  data_out,
    output logic [FIFO_CNTR_W-1:0] cnt,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic                   overflow,
    output logic                   underflow
);

    localparam logic [FIFO_CNTR_W-1:0] DEPTH_C = FIFO_CNTR_W'(FIFO_DEPTH);
    localparam logic [FIFO_CNTR_W-1:0] AF_C    = FIFO_CNTR_W'(AF_THRESH);
    localparam logic [FIFO_CNTR_W-1:0] AE_C    = FIFO_CNTR_W'(AE_THRESH);

    logic [FIFO_WIDTH-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_PNTR_W-1:0] wptr;
    logic [FIFO_PNTR_W-1:0] rptr;
    logic [FIFO_CNTR_W-1:0] count;
    logic                   pop_ok;
    logic                   push_ok;

    // Flags come only from the registered count, never from push/pop.
    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign cnt          = count;
    assign data_out     = empty ? '0 : mem[rptr];

    // A push while full is still accepted when a pop frees the head slot this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or negedge FIFO_clr_n) begin
        if (!FIFO_clr_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (!FIFO_reset_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            overflow  <= (overflow && !err_clr) || (push && !push_ok);
            underflow <= (underflow && !err_clr) || (pop && !pop_ok);
        end
    end

    // Storage carries no reset; stale words are hidden by the empty mask on data_out.
    always_ff @(posedge clk) begin
        if (push_ok && FIFO_reset_n && FIFO_clr_n) begin
            mem[wptr] <= data_in;
        end
    end

endmodule

// File: tb/tb_fifo_flagged.sv
// Directed self-checking bench for fifo_flagged with DEPTH=8, AF=6, AE=2.
module tb_fifo_flagged;

    logic        clk;
    logic        FIFO_clr_n;
    logic        FIFO_reset_n;
    logic        push;
    logic        pop;
    logic [31:0] data_in;
    logic        err_clr;
    logic [31:0] data_out;
    logic [3:0]  cnt;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int total;
    int passed;

    fifo_flagged #(
        .FIFO_WIDTH(32), .FIFO_DEPTH(8), .FIFO_PNTR_W(3),
        .FIFO_CNTR_W(4), .AF_THRESH(6), .AE_THRESH(2)
    ) dut (
        .clk(clk), .FIFO_clr_n(FIFO_clr_n), .FIFO_reset_n(FIFO_reset_n),
        .push(push), .pop(pop), .data_in(data_in), .err_clr(err_clr),
        .data_out(data_out), .cnt(cnt), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; FIFO_reset_n = 1'b1;
    endtask

    task automatic push_word(input logic [31:0] d);
        push = 1'b1; pop = 1'b0; data_in = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        FIFO_clr_n = 1'b0;
        step();
        FIFO_clr_n = 1'b1;
        step();
        total++; if (cnt !== 4'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else passed++;
        total++; if (empty !== 1'b1) $display("FAIL reset_empty got %b want 1", empty); else passed++;
        total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b want 1", almost_empty); else passed++;
        total++; if (full !== 1'b0) $display("FAIL reset_full got %b want 0", full); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b want 0", almost_full); else passed++;
        total++; if (data_out !== 32'h0) $display("FAIL reset_dout got %h want 0", data_out); else passed++;
        total++; if (overflow !== 1'b0 || underflow !== 1'b0)
            $display("FAIL reset_err got ovf=%b unf=%b want 0 0", overflow, underflow); else passed++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 8; i++) begin
            push_word(32'hA0 + i);
            total++; if (cnt !== 4'(i + 1)) $display("FAIL fill_cnt got %0d want %0d", cnt, i + 1); else passed++;
            total++; if (almost_full !== (i + 1 >= 6))
                $display("FAIL fill_af at cnt %0d got %b want %b", i + 1, almost_full, (i + 1 >= 6)); else passed++;
            total++; if (almost_empty !== (i + 1 <= 2))
                $display("FAIL fill_ae at cnt %0d got %b want %b", i + 1, almost_empty, (i + 1 <= 2)); else passed++;
            total++; if (data_out !== 32'hA0) $display("FAIL fill_head got %h want a0", data_out); else passed++;
        end
        total++; if (full !== 1'b1) $display("FAIL fill_full got %b want 1", full); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (data_out !== 32'hA0 + i)
                $display("FAIL drain_dout got %h want %h", data_out, 32'hA0 + i); else passed++;
            pop = 1'b1;
            step();
            idle();
        end
        total++; if (empty !== 1'b1 || cnt !== 4'd0)
            $display("FAIL drain_empty got empty=%b cnt=%0d want 1 0", empty, cnt); else passed++;
        total++; if (data_out !== 32'h0) $display("FAIL drain_dout_mask got %h want 0", data_out); else passed++;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 8; i++) push_word(32'hB0 + i);
        push_word(32'hFF);
        total++; if (cnt !== 4'd8) $display("FAIL ovf_cnt got %0d want 8", cnt); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %b want 1", overflow); else passed++;
        err_clr = 1'b1;
        step();
        idle();
        total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b want 0", overflow); else passed++;
        for (int i = 0; i < 8; i++) begin
            total++; if (data_out !== 32'hB0 + i)
                $display("FAIL ovf_drain got %h want %h", data_out, 32'hB0 + i); else passed++;
            pop = 1'b1;
            step();
            idle();
        end
        total++; if (empty !== 1'b1 || data_out !== 32'h0)
            $display("FAIL ovf_no_ff got empty=%b dout=%h want 1 0", empty, data_out); else passed++;
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) push_word(32'hC0 + i);
        for (int i = 0; i < 20; i++) begin
            total++; if (data_out !== 32'hC0 + i)
                $display("FAIL b2b_dout got %h want %h", data_out, 32'hC0 + i); else passed++;
            push = 1'b1; pop = 1'b1; data_in = 32'hC3 + i;
            step();
            idle();
            total++; if (cnt !== 4'd3) $display("FAIL b2b_cnt got %0d want 3", cnt); else passed++;
        end
        // head is now C0+20 = D4; add 5 more to fill
        for (int i = 0; i < 5; i++) push_word(32'hE0 + i);
        total++; if (full !== 1'b1) $display("FAIL b2b_full got %b want 1", full); else passed++;
        push = 1'b1; pop = 1'b1; data_in = 32'h77;
        step();
        idle();
        total++; if (cnt !== 4'd8) $display("FAIL full_pp_cnt got %0d want 8", cnt); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL full_pp_ovf got %b want 0", overflow); else passed++;
        total++; if (data_out !== 32'hD5) $display("FAIL full_pp_head got %h want d5", data_out); else passed++;
        FIFO_reset_n = 1'b0;
        step();
        idle();
    endtask

    task automatic test_empty_push_pop();
        push = 1'b1; pop = 1'b1; data_in = 32'h5;
        #1;
        total++; if (data_out !== 32'h0) $display("FAIL no_bypass got %h want 0", data_out); else passed++;
        step();
        idle();
        total++; if (cnt !== 4'd1) $display("FAIL epp_cnt got %0d want 1", cnt); else passed++;
        total++; if (underflow !== 1'b1) $display("FAIL epp_unf got %b want 1", underflow); else passed++;
        total++; if (data_out !== 32'h5) $display("FAIL epp_dout got %h want 5", data_out); else passed++;
        pop = 1'b1;
        step();
        pop = 1'b1; err_clr = 1'b1;
        step();
        idle();
        total++; if (underflow !== 1'b1) $display("FAIL set_wins got %b want 1", underflow); else passed++;
        err_clr = 1'b1;
        step();
        idle();
        total++; if (underflow !== 1'b0) $display("FAIL unf_clr got %b want 0", underflow); else passed++;
    endtask

    task automatic test_flush();
        for (int i = 0; i < 5; i++) push_word(32'h10 + i);
        total++; if (cnt !== 4'd5) $display("FAIL pre_flush_cnt got %0d want 5", cnt); else passed++;
        FIFO_reset_n = 1'b0; push = 1'b1; data_in = 32'h99;
        step();
        idle();
        total++; if (cnt !== 4'd0 || empty !== 1'b1)
            $display("FAIL flush_state got cnt=%0d empty=%b want 0 1", cnt, empty); else passed++;
        total++; if (data_out !== 32'h0) $display("FAIL flush_dout got %h want 0", data_out); else passed++;
        push_word(32'h42);
        total++; if (data_out !== 32'h42 || cnt !== 4'd1)
            $display("FAIL post_flush got dout=%h cnt=%0d want 42 1", data_out, cnt); else passed++;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) push_word(32'h60 + i);
        #2;
        FIFO_clr_n = 1'b0;
        #1;
        total++; if (cnt !== 4'd0 || empty !== 1'b1)
            $display("FAIL async_state got cnt=%0d empty=%b want 0 1", cnt, empty); else passed++;
        total++; if (data_out !== 32'h0) $display("FAIL async_dout got %h want 0", data_out); else passed++;
        step();
        FIFO_clr_n = 1'b1;
        step();
        total++; if (cnt !== 4'd0) $display("FAIL async_hold got %0d want 0", cnt); else passed++;
    endtask

    initial begin
        total = 0;
        passed = 0;
        FIFO_clr_n = 1'b0;
        data_in = '0;
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_back_to_back();
        test_empty_push_pop();
        test_flush();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
